// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared constants and helpers for the whack-a-mole score tracker.
//   - default parameter values for score_tracker
//   - clog2     : constant ceiling-log2 used to size counters and intermediates
//   - sat_add   : adds a signed delta to the score and clamps to [0, max_val],
//                 reporting whether the upper clamp was applied
// -----------------------------------------------------------------------------
package score_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int PTS_W_DEF     = 2;
    localparam int SCORE_W_DEF   = 8;
    localparam int PENALTY_DEF   = 1;
    localparam int COMBO_MAX_DEF = 3;

    // Result of a saturating add: clipped flags an upper clamp only.
    typedef struct packed {
        logic        clipped;
        logic [31:0] value;
    } sat_res_t;

    // Ceiling log2 of a positive value (clog2(1) = 0).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Score + signed delta, floored at 0 (no wrap) and capped at max_val.
    function automatic sat_res_t sat_add(input logic signed [31:0] score,
                                         input logic signed [31:0] net,
                                         input logic signed [31:0] max_val);
        logic signed [31:0] sum;
        sat_res_t           res;
        sum = score + net;
        if (sum < 32'sd0) begin
            res.clipped = 1'b0;
            res.value   = 32'd0;
        end else if (sum > max_val) begin
            res.clipped = 1'b1;
            res.value   = max_val;
        end else begin
            res.clipped = 1'b0;
            res.value   = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
// Rising-edge detector: a registered copy of the input history and a
// combinational rise = din & ~history, so an edge is seen in the same cycle
// the level first appears. The history follows din every cycle.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset (clears history)
//   din  in  W  level inputs
//   rise out W  one bit per input, high in the first cycle the input is high
// -----------------------------------------------------------------------------
module edge_rise #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] din_q_r;

    // Level history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q_r <= {W{1'b0}};
        end else begin
            din_q_r <= din;
        end
    end

    assign rise = din & ~din_q_r;

endmodule

// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
// Multi-channel whack-a-mole score keeper. Each rising hit edge adds that
// channel's weighted points, each rising miss edge removes PENALTY. The score
// clamps at 0 and at 2**SCORE_W-1 (sticky sat flag). best holds the highest
// score since rst and new_best pulses for one cycle when it is raised.
// Optional feature macro: SCORE_COMBO_EN -- streak multiplier (combo+1),
// combo saturates at COMBO_MAX and resets on a miss edge.
// Ports:
//   clk      in  1                      clock
//   rst      in  1                      synchronous active-high reset
//   clr      in  1                      new round: clears score/combo/sat
//   hit      in  NUM_CH                 level hit flags
//   pts      in  NUM_CH*PTS_W           per-channel point values
//   miss     in  1                      level miss flag
//   score    out SCORE_W                current round score
//   best     out SCORE_W                best score since rst
//   new_best out 1                      pulse when best is raised
//   sat      out 1                      score clipped at max this round
//   combo    out clog2(COMBO_MAX+1)     current streak
// -----------------------------------------------------------------------------
module score_tracker
    import score_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int PTS_W     = PTS_W_DEF,
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int PENALTY   = PENALTY_DEF,
    parameter int COMBO_MAX = COMBO_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [NUM_CH-1:0]             hit,
    input  logic [NUM_CH*PTS_W-1:0]       pts,
    input  logic                          miss,
    output logic [SCORE_W-1:0]            score,
    output logic [SCORE_W-1:0]            best,
    output logic                          new_best,
    output logic                          sat,
    output logic [clog2(COMBO_MAX+1)-1:0] combo
);

    // Wide enough for score + every channel at max points and max multiplier.
    localparam int IW    = SCORE_W + clog2(NUM_CH) + PTS_W + 3;
    localparam int CW    = clog2(COMBO_MAX + 1);
    localparam int MAX_I = (2 ** SCORE_W) - 1;

    localparam logic signed [IW-1:0] ONE_S = {{(IW-1){1'b0}}, 1'b1};
    localparam logic signed [IW-1:0] PEN_S = IW'(PENALTY);

    logic [NUM_CH-1:0]        hit_rise_s;
    logic                     miss_rise_s;
    logic signed [IW-1:0]     mult_s;
    logic signed [IW-1:0]     add_s;
    logic signed [IW-1:0]     sub_s;
    logic signed [IW-1:0]     net_s;
    sat_res_t                 sat_res_s;
    logic [SCORE_W-1:0]       score_nx_s;

    logic [SCORE_W-1:0]       score_r;
    logic [SCORE_W-1:0]       best_r;
    logic                     new_best_r;
    logic                     sat_r;

    edge_rise #(.W(NUM_CH)) u_hit_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (hit),
        .rise (hit_rise_s)
    );

    edge_rise #(.W(1)) u_miss_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (miss),
        .rise (miss_rise_s)
    );

`ifdef SCORE_COMBO_EN
    logic [CW-1:0] combo_r;

    // Multiplier uses the streak value from before this cycle's update.
    assign mult_s = $signed({{(IW-CW){1'b0}}, combo_r}) + ONE_S;

    // Streak counter: miss edge wins over hits, otherwise any hit edge counts up.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_r <= {CW{1'b0}};
        end else if (clr) begin
            combo_r <= {CW{1'b0}};
        end else if (miss_rise_s) begin
            combo_r <= {CW{1'b0}};
        end else if (|hit_rise_s) begin
            if (combo_r == CW'(COMBO_MAX)) begin
                combo_r <= combo_r;
            end else begin
                combo_r <= combo_r + CW'(1'b1);
            end
        end else begin
            combo_r <= combo_r;
        end
    end

    assign combo = combo_r;
`else
    assign mult_s = ONE_S;
    assign combo  = {CW{1'b0}};
`endif

    // Adder tree over all simultaneous rising channels, penalty and clamp.
    always_comb begin
        add_s = {IW{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit_rise_s[i]) begin
                add_s = add_s + ($signed({{(IW-PTS_W){1'b0}}, pts[i*PTS_W +: PTS_W]}) * mult_s);
            end else begin
                add_s = add_s;
            end
        end
        if (miss_rise_s) begin
            sub_s = PEN_S;
        end else begin
            sub_s = {IW{1'b0}};
        end
        net_s     = add_s - sub_s;
        sat_res_s = sat_add($signed(32'(score_r)), 32'(net_s), MAX_I);
        // Any stray upper bit forces the maximum rather than a wrapped value.
        score_nx_s = sat_res_s.value[SCORE_W-1:0] | {SCORE_W{|sat_res_s.value[31:SCORE_W]}};
    end

    // Round score and sticky saturation flag; clr drops this cycle's edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_r <= {SCORE_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (clr) begin
            score_r <= {SCORE_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            score_r <= score_nx_s;
            sat_r   <= sat_r | sat_res_s.clipped;
        end
    end

    // Best score tracks the registered score one cycle later; survives clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_r     <= {SCORE_W{1'b0}};
            new_best_r <= 1'b0;
        end else if (score_r > best_r) begin
            best_r     <= score_r;
            new_best_r <= 1'b1;
        end else begin
            best_r     <= best_r;
            new_best_r <= 1'b0;
        end
    end

    assign score    = score_r;
    assign best     = best_r;
    assign new_best = new_best_r;
    assign sat      = sat_r;

endmodule

// File: tb/tb_score_tracker.sv
module tb_score_tracker;

    localparam int NCH  = 4;
    localparam int PW   = 2;
    localparam int SW   = 4;
    localparam int PEN  = 1;
    localparam int CMAX = 3;
    localparam int CWD  = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [NCH-1:0]    hit;
    logic [NCH*PW-1:0] pts;
    logic              miss;
    logic [SW-1:0]     score;
    logic [SW-1:0]     best;
    logic              new_best;
    logic              sat;
    logic [CWD-1:0]    combo;

    int checks = 0;
    int errors = 0;

    score_tracker #(
        .NUM_CH(NCH), .PTS_W(PW), .SCORE_W(SW), .PENALTY(PEN), .COMBO_MAX(CMAX)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .hit(hit), .pts(pts), .miss(miss),
        .score(score), .best(best), .new_best(new_best), .sat(sat), .combo(combo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int       m_score, m_best, m_combo;
    bit       m_sat, m_nb;
    bit [3:0] m_hq;
    bit       m_mq;

    task automatic model_step(input bit r, input bit c, input bit [3:0] h,
                              input bit [7:0] p, input bit m);
        int add, mult, t;
        bit miss_edge, any_hit;
        if (r) begin
            m_score = 0; m_best = 0; m_combo = 0; m_sat = 0; m_nb = 0;
            m_hq = 4'd0; m_mq = 1'b0;
        end else begin
            m_nb = (m_score > m_best);
            if (m_nb) m_best = m_score;
            if (c) begin
                m_score = 0; m_sat = 0; m_combo = 0;
            end else begin
`ifdef SCORE_COMBO_EN
                mult = m_combo + 1;
`else
                mult = 1;
`endif
                add = 0; any_hit = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (h[i] && !m_hq[i]) begin
                        add += ((p >> (i * PW)) & 3) * mult;
                        any_hit = 1;
                    end
                end
                miss_edge = m && !m_mq;
                t = m_score + add - (miss_edge ? PEN : 0);
                if (t < 0) t = 0;
                if (t > SMAX) begin t = SMAX; m_sat = 1; end
                m_score = t;
`ifdef SCORE_COMBO_EN
                if (miss_edge) m_combo = 0;
                else if (any_hit && m_combo < CMAX) m_combo = m_combo + 1;
`endif
            end
            m_hq = h; m_mq = m;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int sc, input int be,
                             input int nb, input int sa, input int co);
        check({tag, ".score"},    int'(score),    sc);
        check({tag, ".best"},     int'(best),     be);
        check({tag, ".new_best"}, int'(new_best), nb);
        check({tag, ".sat"},      int'(sat),      sa);
        check({tag, ".combo"},    int'(combo),    co);
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge.
    task automatic step(input bit r, input bit c, input bit [3:0] h,
                        input bit [7:0] p, input bit m);
        rst = r; clr = c; hit = h; pts = p; miss = m;
        @(posedge clk);
        #1;
        model_step(r, c, h, p, m);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       clr;
        bit [3:0] hit;
        bit [7:0] pts;
        bit       miss;
        int       sc, be, nb, sa, co;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit c, input bit [3:0] h, input bit [7:0] p,
                                input bit m, input int sc, input int be,
                                input int nb, input int sa, input int co);
        vec_t v;
        v.clr = c; v.hit = h; v.pts = p; v.miss = m;
        v.sc = sc; v.be = be; v.nb = nb; v.sa = sa; v.co = co;
        return v;
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; hit = 4'd0; pts = 8'd0; miss = 1'b0;
`ifdef SCORE_COMBO_EN
        // streak multiplier 1,2,3,4 then capped at 4; hit+miss scores at old mult
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  1,  0, 0, 0, 1));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  1,  1, 1, 0, 1));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  3,  1, 0, 0, 2));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  3,  3, 1, 0, 2));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  6,  3, 0, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  6,  6, 1, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0, 10,  6, 0, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0, 10, 10, 1, 0, 3));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h01, 1'b0,  0, 10, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  1, 10, 0, 0, 1));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  1, 10, 0, 0, 1));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  3, 10, 0, 0, 2));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  3, 10, 0, 0, 2));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  6, 10, 0, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  6, 10, 0, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0, 10, 10, 0, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0, 10, 10, 0, 0, 3));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b1, 13, 10, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0, 13, 13, 1, 0, 0));
`else
        // T1: single hit, then held level
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0,  2,  0, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0,  2,  2, 1, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0,  2,  2, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0,  2,  2, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0,  2,  2, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0,  2,  2, 0, 0, 0));
        // T2: two channels rise together
        vecs.push_back(mk(1'b0, 4'b0111, 8'h1E, 1'b0,  6,  2, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h1E, 1'b0,  6,  6, 1, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h1E, 1'b0,  6,  6, 0, 0, 0));
        // T3: floor at zero
        vecs.push_back(mk(1'b1, 4'b0000, 8'h00, 1'b0,  0,  6, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0,  1,  6, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b1,  0,  6, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b0,  0,  6, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h01, 1'b1,  0,  6, 0, 0, 0));
        // T4: climb to 14, clip at 15, sticky sat until clr
        vecs.push_back(mk(1'b0, 4'b1111, 8'hFF, 1'b0, 12,  6, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'hFF, 1'b0, 12, 12, 1, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h02, 1'b0, 14, 12, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h02, 1'b0, 14, 14, 1, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0010, 8'h0C, 1'b0, 15, 14, 0, 1, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h0C, 1'b0, 15, 15, 1, 1, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h0C, 1'b1, 14, 15, 0, 1, 0));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 1'b0, 15, 15, 0, 1, 0));
        vecs.push_back(mk(1'b0, 4'b0011, 8'h09, 1'b1, 15, 15, 0, 1, 0));
        vecs.push_back(mk(1'b1, 4'b0011, 8'h09, 1'b0,  0, 15, 0, 0, 0));
        // T6: levels held across clr and edges during clr never score
        vecs.push_back(mk(1'b0, 4'b0011, 8'h09, 1'b0,  0, 15, 0, 0, 0));
        vecs.push_back(mk(1'b1, 4'b0111, 8'h19, 1'b0,  0, 15, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0111, 8'h19, 1'b0,  0, 15, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b0000, 8'h19, 1'b1,  0, 15, 0, 0, 0));
        vecs.push_back(mk(1'b0, 4'b1000, 8'h80, 1'b0,  2, 15, 0, 0, 0));
`endif

        // reset state
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
        check_all("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].clr, vecs[i].hit, vecs[i].pts, vecs[i].miss);
            check_all($sformatf("vec%0d", i), vecs[i].sc, vecs[i].be,
                      vecs[i].nb, vecs[i].sa, vecs[i].co);
        end

        // mid-round reset with a hit level still held clears everything
        step(1'b1, 1'b0, 4'b1000, 8'h80, 1'b0);
        check_all("midrst", 0, 0, 0, 0, 0);
        // history was cleared, so a level present on release counts as a new edge
        step(1'b0, 1'b0, 4'b1000, 8'h80, 1'b0);
        check("postrst.score", int'(score), 2);

        // randomized run against the reference model
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            bit       r, c, m;
            bit [3:0] h;
            bit [7:0] p;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 19) == 0);
            m = ($urandom_range(0, 3) == 0);
            h = 4'($urandom_range(0, 15));
            p = 8'($urandom_range(0, 255));
            step(r, c, h, p, m);
            check_all($sformatf("rnd%0d", n), m_score, m_best, int'(m_nb),
                      int'(m_sat), m_combo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
